// File: rtl/plot_framebuffer.sv
// plot_framebuffer: receiving end of the pixel-plot interface.
// Holds a WIDTH x HEIGHT x 3-bit framebuffer with a single write port shared
// between incoming plots and a built-in clear engine (start/done handshake),
// plus a registered readback port with read-before-write behaviour.
// Optional feature macro: PLOT_FRAMEBUFFER_RANGE_ERR_EN enables a sticky
// range_err flag for out-of-range plots; when undefined range_err stays 0.
module plot_framebuffer #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int AW     = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] vga_x,
    input  logic [6:0] vga_y,
    input  logic [2:0] vga_colour,
    input  logic       vga_plot,
    input  logic       rd_req,
    input  logic [7:0] rd_x,
    input  logic [6:0] rd_y,
    output logic       rd_valid,
    output logic [2:0] rd_colour,
    input  logic       clr_start,
    input  logic [2:0] clr_colour,
    output logic       clr_done,
    output logic       busy,
    output logic       range_err
);

    localparam int DEPTH = WIDTH * HEIGHT;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t        state_r;
    logic [AW-1:0] clr_cnt_r;
    logic [2:0]    clr_colour_r;
    logic          busy_r;
    logic          clr_done_r;
    logic          rd_valid_r;
    logic [2:0]    rd_colour_r;
    logic          range_err_r;

    logic [2:0]    mem_r [0:DEPTH-1];

    logic          plot_ok_s;
    logic          plot_oob_s;
    logic          rd_ok_s;
    logic [AW-1:0] plot_addr_s;
    logic [AW-1:0] rd_addr_s;
    logic          wr_en_s;
    logic [AW-1:0] wr_addr_s;
    logic [2:0]    wr_data_s;

    // Linear pixel address; wide enough that in-range coordinates never wrap.
    function automatic logic [AW-1:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
        return AW'(y) * AW'(WIDTH) + AW'(x);
    endfunction

    // True when the coordinate lies inside the visible area.
    function automatic logic in_range(input logic [7:0] x, input logic [6:0] y);
        return (x < 8'(WIDTH)) && (y < 7'(HEIGHT));
    endfunction

    // Decode plot/readback requests and arbitrate the single RAM write port.
    always_comb begin
        plot_addr_s = pix_addr(vga_x, vga_y);
        rd_addr_s   = pix_addr(rd_x, rd_y);
        rd_ok_s     = in_range(rd_x, rd_y);
        plot_ok_s   = vga_plot && !busy_r && in_range(vga_x, vga_y);
        plot_oob_s  = vga_plot && !busy_r && !in_range(vga_x, vga_y);
        wr_en_s     = 1'b0;
        wr_addr_s   = {AW{1'b0}};
        wr_data_s   = 3'd0;
        if (busy_r) begin
            wr_en_s   = 1'b1;
            wr_addr_s = clr_cnt_r;
            wr_data_s = clr_colour_r;
        end else if (plot_ok_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = plot_addr_s;
            wr_data_s = vga_colour;
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Framebuffer storage; contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_addr_s] <= wr_data_s;
        end
    end

    // Registered readback; sees the pre-write value on a same-cycle collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_r  <= 1'b0;
            rd_colour_r <= 3'd0;
        end else begin
            rd_valid_r <= rd_req;
            if (rd_req) begin
                rd_colour_r <= rd_ok_s ? mem_r[rd_addr_s] : 3'd0;
            end
        end
    end

    // Clear engine: sweep every address once with the latched colour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            clr_cnt_r    <= {AW{1'b0}};
            clr_colour_r <= 3'd0;
            busy_r       <= 1'b0;
            clr_done_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (clr_start) begin
                        state_r      <= ST_CLEAR;
                        clr_colour_r <= clr_colour;
                        clr_cnt_r    <= {AW{1'b0}};
                        busy_r       <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt_r == AW'(DEPTH - 1)) begin
                        state_r    <= ST_DONE;
                        busy_r     <= 1'b0;
                        clr_done_r <= 1'b1;
                    end else begin
                        clr_cnt_r <= clr_cnt_r + {{(AW-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    if (!clr_start) begin
                        state_r    <= ST_IDLE;
                        clr_done_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                    clr_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Sticky out-of-range indication for accepted-but-dropped plots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            range_err_r <= 1'b0;
        end else begin
`ifdef PLOT_FRAMEBUFFER_RANGE_ERR_EN
            if (plot_oob_s) begin
                range_err_r <= 1'b1;
            end
`else
            range_err_r <= 1'b0;
`endif
        end
    end

    assign rd_valid  = rd_valid_r;
    assign rd_colour = rd_colour_r;
    assign clr_done  = clr_done_r;
    assign busy      = busy_r;
`ifdef PLOT_FRAMEBUFFER_RANGE_ERR_EN
    assign range_err = range_err_r;
`else
    assign range_err = range_err_r & plot_oob_s & 1'b0;
`endif

endmodule

// File: tb/tb_plot_framebuffer.sv
// Self-checking bench for plot_framebuffer: vector table of plot/read pairs,
// readback scoreboard queue, and hand-written clear/reset sequences.
module tb_plot_framebuffer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] vga_x = 8'd0;
    logic [6:0] vga_y = 7'd0;
    logic [2:0] vga_colour = 3'd0;
    logic       vga_plot = 1'b0;
    logic       rd_req = 1'b0;
    logic [7:0] rd_x = 8'd0;
    logic [6:0] rd_y = 7'd0;
    logic       rd_valid;
    logic [2:0] rd_colour;
    logic       clr_start = 1'b0;
    logic [2:0] clr_colour = 3'd0;
    logic       clr_done;
    logic       busy;
    logic       range_err;

    int total = 0;
    int bad = 0;
    logic [2:0] exp_q[$];

`ifdef PLOT_FRAMEBUFFER_RANGE_ERR_EN
    localparam logic RERR_EXP = 1'b1;
`else
    localparam logic RERR_EXP = 1'b0;
`endif

    plot_framebuffer dut (
        .clk(clk), .rst_n(rst_n),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y),
        .rd_valid(rd_valid), .rd_colour(rd_colour),
        .clr_start(clr_start), .clr_colour(clr_colour),
        .clr_done(clr_done), .busy(busy), .range_err(range_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every valid readback is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected_valid", 1, 0);
            end else begin
                check("rd_colour", int'(rd_colour), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic plot(input int x, input int y, input int c);
        vga_x = 8'(x); vga_y = 7'(y); vga_colour = 3'(c); vga_plot = 1'b1;
        step();
        vga_plot = 1'b0;
    endtask

    task automatic read(input int x, input int y, input int e);
        rd_x = 8'(x); rd_y = 7'(y); rd_req = 1'b1;
        exp_q.push_back(3'(e));
        step();
        rd_req = 1'b0;
    endtask

    // Hold clr_start until done; returns number of cycles busy was seen high.
    task automatic run_clear(input int colour, input int stop_at, output int cnt, output logic done);
        cnt = 0;
        done = 1'b0;
        clr_colour = 3'(colour);
        clr_start = 1'b1;
        for (int i = 0; i < 25000; i++) begin
            step();
            if (busy) cnt++;
            if (clr_done) begin
                done = 1'b1;
                break;
            end
            if (stop_at > 0 && cnt == stop_at) break;
        end
    endtask

    typedef struct {
        int px; int py; int pc;
        int rx; int ry; int exp;
    } vec_t;

    vec_t vecs[8];
    int   cnt;
    logic done;

    initial begin
        vecs[0] = '{0,   0,   1, 0,   0,   1};
        vecs[1] = '{159, 119, 7, 159, 119, 7};
        vecs[2] = '{159, 0,   2, 159, 0,   2};
        vecs[3] = '{0,   119, 5, 0,   119, 5};
        vecs[4] = '{160, 0,   7, 160, 0,   0};
        vecs[5] = '{160, 0,   7, 0,   1,   6};
        vecs[6] = '{0,   120, 3, 0,   120, 0};
        vecs[7] = '{200, 5,   7, 40,  6,   6};

        #12;
        check("reset_rd_valid", int'(rd_valid), 0);
        check("reset_rd_colour", int'(rd_colour), 0);
        check("reset_clr_done", int'(clr_done), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_range_err", int'(range_err), 0);
        rst_n = 1'b1;
        step();

        // Basic plot then readback one cycle later.
        plot(5, 7, 3);
        read(5, 7, 3);
        step();

        // Full clear with colour 6; plot mid-clear and colour change are ignored.
        clr_colour = 3'd6;
        clr_start = 1'b1;
        cnt = 0;
        done = 1'b0;
        for (int i = 0; i < 25000; i++) begin
            step();
            if (busy) cnt++;
            vga_plot = 1'b0;
            if (cnt == 5000) begin
                vga_x = 8'd10; vga_y = 7'd10; vga_colour = 3'd2; vga_plot = 1'b1;
            end
            if (cnt == 100) clr_colour = 3'd4;
            if (clr_done) begin
                done = 1'b1;
                break;
            end
        end
        vga_plot = 1'b0;
        check("clr_busy_cycles", cnt, 19200);
        check("clr_done_seen", int'(done), 1);
        check("done_busy_low", int'(busy), 0);
        step(); step(); step();
        check("done_held", int'(clr_done), 1);
        read(0, 0, 6);
        read(159, 119, 6);
        read(80, 60, 6);
        read(10, 10, 6);
        clr_start = 1'b0;
        step();
        check("done_drop", int'(clr_done), 0);
        check("range_err_clean", int'(range_err), 0);

        // Vector table: plot then read back.
        for (int i = 0; i < 8; i++) begin
            plot(vecs[i].px, vecs[i].py, vecs[i].pc);
            read(vecs[i].rx, vecs[i].ry, vecs[i].exp);
        end
        check("range_err_after_oob", int'(range_err), int'(RERR_EXP));

        // Back-to-back plots at one per cycle.
        plot(20, 30, 1);
        plot(21, 30, 2);
        plot(22, 30, 3);
        read(20, 30, 1);
        read(21, 30, 2);
        read(22, 30, 3);

        // Same-cycle write and read at (1,1): old value first, new value next.
        vga_x = 8'd1; vga_y = 7'd1; vga_colour = 3'd5; vga_plot = 1'b1;
        rd_x = 8'd1; rd_y = 7'd1; rd_req = 1'b1;
        exp_q.push_back(3'd6);
        step();
        vga_plot = 1'b0;
        exp_q.push_back(3'd5);
        step();
        rd_req = 1'b0;
        step();

        // Reset in the middle of a clear.
        run_clear(3, 1000, cnt, done);
        check("partial_clear_cycles", cnt, 1000);
        rst_n = 1'b0;
        clr_start = 1'b0;
        #1;
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_done", int'(clr_done), 0);
        check("rst_mid_range_err", int'(range_err), 0);
        step();
        rst_n = 1'b1;
        step();
        check("idle_after_rst", int'(busy), 0);

        // Fresh clear with colour 1 completes normally.
        run_clear(1, 0, cnt, done);
        check("clr2_busy_cycles", cnt, 19200);
        check("clr2_done_seen", int'(done), 1);
        read(159, 119, 1);
        read(0, 0, 1);
        clr_start = 1'b0;
        step();
        check("clr2_done_drop", int'(clr_done), 0);
        step();
        check("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
